// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler
//
// Walks every (row, col, n, m) tile of one convolution layer and drives the
// tile engine's start/done handshake for each of them. The m loop is the
// innermost one, so partial sums accumulate across input channels before
// the output-channel base moves on.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   layer_start     one-cycle request to process the whole layer (in)
//   layer_done      one-cycle pulse after the last tile completes (out)
//   busy            high from acceptance of layer_start until layer_done (out)
//   conv_tile_start one-cycle start pulse to the tile engine (out)
//   conv_tile_done  one-cycle completion pulse from the tile engine (in)
//   tile_base_n     output-channel base of the current tile (out, AW)
//   tile_base_m     input-channel base of the current tile (out, AW)
//   tile_base_row   row base of the current tile (out, AW)
//   tile_base_col   column base of the current tile (out, AW)
//   tile_idx        zero-based index of the current tile (out, AW)
module conv_tile_scheduler #(
  parameter int AW       = 32,
  parameter int N        = 32,
  parameter int M        = 32,
  parameter int R        = 64,
  parameter int C        = 32,
  parameter int Tn       = 16,
  parameter int Tm       = 16,
  parameter int Tr       = 64,
  parameter int Tc       = 16,
  parameter int TILE_GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  output logic          layer_done,
  output logic          busy,
  output logic          conv_tile_start,
  input  logic          conv_tile_done,
  output logic [AW-1:0] tile_base_n,
  output logic [AW-1:0] tile_base_m,
  output logic [AW-1:0] tile_base_row,
  output logic [AW-1:0] tile_base_col,
  output logic [AW-1:0] tile_idx
);

  localparam int NUM_TILES = (N / Tn) * (M / Tm) * (R / Tr) * (C / Tc);

  // Each base wraps once it sits at (bound - step).
  localparam logic [AW-1:0] N_LAST   = AW'(N - Tn);
  localparam logic [AW-1:0] M_LAST   = AW'(M - Tm);
  localparam logic [AW-1:0] ROW_LAST = AW'(R - Tr);
  localparam logic [AW-1:0] COL_LAST = AW'(C - Tc);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_TILES - 1);

  // Gap counter counts 0 .. TILE_GAP-1 while in GAP.
  localparam int GW = (TILE_GAP > 1) ? $clog2(TILE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((TILE_GAP > 0) ? (TILE_GAP - 1) : 0);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    FINISH
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [GW-1:0] gap_cnt_reg;
  logic [AW-1:0] base_n_reg;
  logic [AW-1:0] base_m_reg;
  logic [AW-1:0] base_row_reg;
  logic [AW-1:0] base_col_reg;
  logic [AW-1:0] idx_reg;

  logic clear_cnt;
  logic advance;
  logic last_tile;

  assign last_tile = (idx_reg == IDX_LAST);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic and counter control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    clear_cnt  = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (layer_start) begin
          state_next = ISSUE;
          clear_cnt  = 1'b1;
        end
      end
      ISSUE: begin
        // A done arriving together with the start pulse is not ours.
        state_next = WAIT;
      end
      WAIT: begin
        if (conv_tile_done) begin
          if (last_tile) begin
            state_next = FINISH;
          end else begin
            advance    = 1'b1;
            state_next = (TILE_GAP == 0) ? ISSUE : GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ISSUE;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Idle-gap counter: restarts from zero every time GAP is entered
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_reg <= '0;
    end else if (state_reg != GAP) begin
      gap_cnt_reg <= '0;
    end else begin
      gap_cnt_reg <= gap_cnt_reg + GW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Tile base counters, nested row > col > n > m with ripple carry.
  // They hold after the last tile so the final coordinates stay visible.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      base_n_reg   <= '0;
      base_m_reg   <= '0;
      base_row_reg <= '0;
      base_col_reg <= '0;
      idx_reg      <= '0;
    end else if (advance) begin
      idx_reg <= idx_reg + AW'(1);
      if (base_m_reg != M_LAST) begin
        base_m_reg <= base_m_reg + AW'(Tm);
      end else begin
        base_m_reg <= '0;
        if (base_n_reg != N_LAST) begin
          base_n_reg <= base_n_reg + AW'(Tn);
        end else begin
          base_n_reg <= '0;
          if (base_col_reg != COL_LAST) begin
            base_col_reg <= base_col_reg + AW'(Tc);
          end else begin
            base_col_reg <= '0;
            if (base_row_reg != ROW_LAST) begin
              base_row_reg <= base_row_reg + AW'(Tr);
            end else begin
              base_row_reg <= '0;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: pulses decode straight from the registered state
  // ---------------------------------------------------------------------
  assign conv_tile_start = (state_reg == ISSUE);
  assign layer_done      = (state_reg == FINISH);
  assign busy            = (state_reg != IDLE);
  assign tile_base_n     = base_n_reg;
  assign tile_base_m     = base_m_reg;
  assign tile_base_row   = base_row_reg;
  assign tile_base_col   = base_col_reg;
  assign tile_idx        = idx_reg;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Testbench for conv_tile_scheduler.
// Four scheduler instances with different tilings run side by side; the
// stimulus process exercises them one at a time, an engine model answers
// each start with a done, and a monitor compares everything the DUTs present
// against a queue of expected tiles produced from nested loops.
module tb_conv_tile_scheduler;

  localparam int NI = 4;
  // 0: defaults (8 tiles, gap 2)  1: defaults with gap 0
  // 2: single tile                3: non-square (4 tiles, gap 1)
  localparam int P_N   [NI] = '{32, 32, 16, 16};
  localparam int P_M   [NI] = '{32, 32, 16, 32};
  localparam int P_R   [NI] = '{64, 64, 64, 128};
  localparam int P_C   [NI] = '{32, 32, 16, 32};
  localparam int P_TN  [NI] = '{16, 16, 16, 16};
  localparam int P_TM  [NI] = '{16, 16, 16, 16};
  localparam int P_TR  [NI] = '{64, 64, 64, 64};
  localparam int P_TC  [NI] = '{16, 16, 16, 32};
  localparam int P_GAP [NI] = '{2, 0, 2, 1};

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] n;
    logic [31:0] m;
    logic [31:0] idx;
  } tile_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a     [NI];
  logic        ls_a      [NI];
  logic        td_a      [NI];
  logic        spur_iss  [NI];
  logic        spur_idle [NI];
  logic        done_a    [NI];
  logic        busy_a    [NI];
  logic        start_a   [NI];
  logic [31:0] bn_a      [NI];
  logic [31:0] bm_a      [NI];
  logic [31:0] br_a      [NI];
  logic [31:0] bc_a      [NI];
  logic [31:0] idx_a     [NI];
  bit          eng_done  [NI];
  int          eng_cnt   [NI];
  int          dly_fix   [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    conv_tile_scheduler #(
      .AW(32), .N(P_N[gi]), .M(P_M[gi]), .R(P_R[gi]), .C(P_C[gi]),
      .Tn(P_TN[gi]), .Tm(P_TM[gi]), .Tr(P_TR[gi]), .Tc(P_TC[gi]),
      .TILE_GAP(P_GAP[gi])
    ) u_dut (
      .clk(clk),
      .rst(rst_a[gi]),
      .layer_start(ls_a[gi]),
      .layer_done(done_a[gi]),
      .busy(busy_a[gi]),
      .conv_tile_start(start_a[gi]),
      .conv_tile_done(td_a[gi]),
      .tile_base_n(bn_a[gi]),
      .tile_base_m(bm_a[gi]),
      .tile_base_row(br_a[gi]),
      .tile_base_col(bc_a[gi]),
      .tile_idx(idx_a[gi])
    );
    // Spurious dones: one riding on the start pulse, one forced while idle.
    assign td_a[gi] = eng_done[gi] | (spur_iss[gi] & start_a[gi]) | spur_idle[gi];
  end

  // Engine model: done pulse a fixed or random number of cycles after start.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_a[i]) begin
        eng_cnt[i]  <= 0;
        eng_done[i] <= 1'b0;
      end else if (start_a[i]) begin
        eng_cnt[i]  <= (dly_fix[i] != 0) ? dly_fix[i] : int'($urandom_range(30, 1));
        eng_done[i] <= 1'b0;
      end else if (eng_cnt[i] > 0) begin
        eng_cnt[i]  <= eng_cnt[i] - 1;
        eng_done[i] <= (eng_cnt[i] == 1);
      end else begin
        eng_done[i] <= 1'b0;
      end
    end
  end

  // Inputs as the DUT saw them on the most recent edge.
  int cyc = 0;
  bit rst_q [NI];
  bit ls_q  [NI];
  bit td_q  [NI];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      rst_q[i] <= rst_a[i];
      ls_q[i]  <= ls_a[i];
      td_q[i]  <= td_a[i];
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------
  int    tests = 0;
  int    fails = 0;
  tile_t exp_q [NI][$];
  tile_t cur   [NI];
  bit    run   [NI];
  bit    issue_prev [NI];
  bit    wait_prev  [NI];
  bit    fin_prev   [NI];
  int    exp_start  [NI];
  int    exp_done   [NI];
  int    last_evt   [NI];
  int    nstarts    [NI];
  bit    issue_now, wait_now, fin_now;
  tile_t got_t, fill_t;
  int    fill_k;

  task automatic chk(input string nm, input int i, input logic [191:0] got,
                     input logic [191:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, i, cyc, got, want);
    end
  endtask

  function automatic int num_tiles(input int i);
    return (P_N[i] / P_TN[i]) * (P_M[i] / P_TM[i]) * (P_R[i] / P_TR[i]) * (P_C[i] / P_TC[i]);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      issue_now = 1'b0;
      wait_now  = 1'b0;
      fin_now   = 1'b0;
      got_t = {br_a[i], bc_a[i], bn_a[i], bm_a[i], idx_a[i]};
      if (rst_q[i]) begin
        chk("reset_outputs", i, 192'({busy_a[i], start_a[i], done_a[i], got_t}), 192'(0));
        run[i] = 1'b0; issue_prev[i] = 1'b0; wait_prev[i] = 1'b0; fin_prev[i] = 1'b0;
        exp_start[i] = -1; exp_done[i] = -1;
        exp_q[i].delete();
      end else begin
        // Done sampled at the edge that ended a WAIT cycle.
        if (wait_prev[i] && td_q[i]) begin
          last_evt[i] = cyc;
          if (exp_q[i].size() == 0) begin
            exp_done[i] = cyc;
            fin_now = 1'b1;
          end else begin
            exp_start[i] = cyc + P_GAP[i];
          end
        end else if (wait_prev[i]) begin
          wait_now = 1'b1;
        end
        if (issue_prev[i]) wait_now = 1'b1;
        // Layer request accepted only when idle.
        if (!run[i] && ls_q[i]) begin
          run[i] = 1'b1;
          exp_start[i] = cyc;
          last_evt[i] = cyc;
          nstarts[i] = 0;
          exp_q[i].delete();
          fill_k = 0;
          for (int r = 0; r < P_R[i]; r += P_TR[i])
            for (int c = 0; c < P_C[i]; c += P_TC[i])
              for (int n = 0; n < P_N[i]; n += P_TN[i])
                for (int m = 0; m < P_M[i]; m += P_TM[i]) begin
                  fill_t = {32'(r), 32'(c), 32'(n), 32'(m), 32'(fill_k)};
                  exp_q[i].push_back(fill_t);
                  fill_k++;
                end
        end
        if (fin_prev[i]) run[i] = 1'b0;
        issue_now = run[i] && (exp_start[i] == cyc);

        chk("busy", i, 192'(busy_a[i]), 192'(run[i]));
        if (start_a[i] || issue_now) begin
          chk("tile_start", i, 192'(start_a[i]), 192'(issue_now));
          if (start_a[i]) nstarts[i]++;
          if (issue_now && exp_q[i].size() > 0) begin
            cur[i] = exp_q[i].pop_front();
            chk("tile_coords", i, 192'(got_t), 192'(cur[i]));
            last_evt[i] = cyc;
          end
        end
        if (wait_now) chk("tile_hold", i, 192'(got_t), 192'(cur[i]));
        if (done_a[i] || fin_now) begin
          chk("layer_done", i, 192'(done_a[i]), 192'(fin_now));
          if (fin_now) chk("tile_count", i, 192'(nstarts[i]), 192'(num_tiles(i)));
        end
        if (run[i] && (cyc - last_evt[i] > 400)) begin
          chk("progress_timeout", i, 192'(cyc - last_evt[i]), 192'(400));
          run[i] = 1'b0;
          wait_now = 1'b0;
          fin_now = 1'b0;
          exp_q[i].delete();
        end
      end
      issue_prev[i] = issue_now;
      wait_prev[i]  = wait_now;
      fin_prev[i]   = fin_now;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic pulse_ls(input int i);
    @(negedge clk);
    ls_a[i] = 1'b1;
    @(negedge clk);
    ls_a[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 3000 && busy_a[i]; n++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tile(input int i, input int v);
    for (int n = 0; n < 3000 && !(start_a[i] && idx_a[i] == 32'(v)); n++) @(negedge clk);
  endtask

  task automatic run_layer(input int i);
    pulse_ls(i);
    wait_idle(i);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_a[i] = 1'b1;
      ls_a[i] = 1'b0;
      spur_iss[i] = 1'b0;
      spur_idle[i] = 1'b0;
      dly_fix[i] = 0;
    end
    dly_fix[0] = 20;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;
    repeat (2) @(negedge clk);

    // Default layer, engine answering 20 cycles after each start.
    run_layer(0);

    // Gap 0, single tile and non-square tilings with random engine delay.
    for (int rep = 0; rep < 2; rep++)
      for (int i = 1; i < NI; i++) run_layer(i);

    // Spurious done while idle and on every start; layer_start during tile 3.
    dly_fix[0] = 0;
    spur_idle[0] = 1'b1;
    repeat (2) @(negedge clk);
    spur_idle[0] = 1'b0;
    spur_iss[0] = 1'b1;
    pulse_ls(0);
    wait_tile(0, 3);
    ls_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    ls_a[0] = 1'b0;
    wait_idle(0);
    spur_iss[0] = 1'b0;

    // Reset during WAIT of tile 5, then a clean restart.
    dly_fix[0] = 20;
    pulse_ls(0);
    wait_tile(0, 5);
    @(negedge clk);
    rst_a[0] = 1'b1;
    @(negedge clk);
    rst_a[0] = 1'b0;
    repeat (30) @(negedge clk);
    run_layer(0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_tile_scheduler.md
Name: conv_tile_scheduler

Overview:
Layer-level initiator that drives the tile-level convolution engine's start/done handshake. It walks every (row, col, n, m) tile of one convolution layer and presents the tile base coordinates for each tile. It pulses the engine's start, waits for the engine's done, then advances to the next tile. It sits between the layer controller (layer start/done) and the convolution tile engine (conv_tile_start, conv_tile_done, tile_base_*).

Parameters:
AW, 32, width of tile base coordinate outputs
N, 32, output channels of the layer
M, 32, input channels of the layer
R, 64, output feature rows
C, 32, output feature columns
Tn, 16, output-channel tile size; N must be a multiple of Tn
Tm, 16, input-channel tile size; M must be a multiple of Tm
Tr, 64, row tile size; R must be a multiple of Tr
Tc, 16, column tile size; C must be a multiple of Tc
TILE_GAP, 2, idle cycles between conv_tile_done and the next conv_tile_start (0 allowed)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
layer_start  input  1  one-cycle request to process the whole layer
layer_done  output  1  one-cycle pulse after the last tile completes
busy  output  1  high from acceptance of layer_start until layer_done
conv_tile_start  output  1  one-cycle pulse to the tile engine
conv_tile_done  input  1  one-cycle pulse from the tile engine
tile_base_n  output  AW  output-channel base of the current tile
tile_base_m  output  AW  input-channel base of the current tile
tile_base_row  output  AW  row base of the current tile
tile_base_col  output  AW  column base of the current tile
tile_idx  output  AW  zero-based index of the current tile

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0. State returns to IDLE. All counters are cleared.
- Tile count: (N/Tn)*(M/Tm)*(R/Tr)*(C/Tc). The defaults give 2*2*1*2 = 8 tiles.
- Loop order, outermost to innermost: row, col, n, m.
  - m is innermost so partial sums accumulate across input channels before n advances.
  - Bases step by Tr, Tc, Tn, Tm respectively.
  - Each base wraps to 0 when the next step would reach its bound, and the next outer counter increments.
- FSM states: IDLE, ISSUE, WAIT, GAP, FINISH.
  - IDLE: layer_start=1 at edge k moves to ISSUE and clears bases and tile_idx. busy=1 from cycle k+1.
  - ISSUE: conv_tile_start=1 for exactly this one cycle. Moves to WAIT next edge.
  - WAIT: holds until conv_tile_done=1 is sampled.
    - If the tile is the last one, go to FINISH.
    - Otherwise advance the counters and tile_idx on that same edge, then go to GAP, or to ISSUE directly if TILE_GAP=0.
  - GAP: counts TILE_GAP cycles, then goes to ISSUE.
  - FINISH: layer_done=1 for one cycle. busy drops on the same edge that leaves FINISH. Returns to IDLE. Bases and tile_idx keep the last tile's values.
- Timing:
  - conv_tile_start is high in cycle k+1 after layer_start is sampled at edge k.
  - When conv_tile_done is sampled at edge j, the next conv_tile_start is high in cycle j+1+TILE_GAP.
  - For the last tile, layer_done is high in cycle j+1.
- tile_base_* and tile_idx are registered and stable from the ISSUE cycle through the end of WAIT for that tile. They change only on the advance edge.
- layer_start while busy (any state other than IDLE) is ignored.
- conv_tile_done outside WAIT is ignored.
- conv_tile_done in the same cycle as conv_tile_start (ISSUE) is ignored. Only WAIT samples it.
- rst asserted mid-layer aborts immediately: IDLE, outputs 0, no layer_done. A later layer_start restarts from tile 0.
- Arithmetic: base counters are AW bits wide, with compare against (bound − step). tile_idx is AW bits and increments by 1.

Test Plan:
- Defaults, with an engine model returning done 20 cycles after each start:
  - Exactly 8 conv_tile_start pulses.
  - (row,col,n,m) sequence: (0,0,0,0),(0,0,0,16),(0,0,16,0),(0,0,16,16),(0,16,0,0),(0,16,0,16),(0,16,16,0),(0,16,16,16).
  - tile_idx runs 0..7.
  - layer_done occurs once, 1 cycle after the 8th done.
- Start-to-start latency, TILE_GAP=2: conv_tile_start in cycle k+1 after layer_start at edge k. After done sampled at edge j, the next start is high in cycle j+3. With TILE_GAP=0 it is high in cycle j+1.
- Single-tile configuration (N=Tn, M=Tm, R=Tr, C=Tc): one start, all bases 0, layer_done in the cycle after the done is sampled. busy then drops on the next edge.
- layer_start pulsed during tile 3 and spurious conv_tile_done pulsed in IDLE and in the ISSUE cycle: tile sequence is unchanged and no extra starts occur.
- rst asserted during WAIT of tile 5: all outputs 0 the next cycle and no layer_done. A following layer_start restarts at tile_idx 0 with all bases 0.
- Non-square tiling (R=128, Tr=64, C=32, Tc=32, N=Tn=16, M=32, Tm=16): 4 tiles, with row bases 0,0,64,64 and m bases 0,16,0,16.
